byteswap_control_s_axi: RTL and testbench

- AXI4-Lite slave register file directly upstream of the byteswap kernel top.
- Host software writes xfer_size, gmem_ptr and ap_start through it; it drives the kernel's ap_start, xfer_size and gmem_ptr inputs.
- It captures the kernel's ap_done, ap_ready and ap_idle into status and interrupt registers.
- Provides the standard ap_ctrl_hs control protocol plus a level interrupt.

---
 rtl/byteswap_control_s_axi.sv | 220 ++++++++++++++++++++++
 tb/tb_byteswap_control_s_axi.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/byteswap_control_s_axi.sv
// AXI4-Lite control/status register file for the byteswap kernel.
// Provides the ap_ctrl_hs start/done/ready/idle handshake, kernel arguments and a level interrupt.
module byteswap_control_s_axi #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH      = 6,
  parameter int unsigned C_S_AXI_DATA_WIDTH      = 32,
  parameter int unsigned C_XFER_SIZE_WIDTH       = 32,
  parameter int unsigned C_M_AXI_GMEM_ADDR_WIDTH = 64
) (
  input  logic                            ap_clk,
  input  logic                            areset,
  input  logic                            s_axi_control_AWVALID,
  output logic                            s_axi_control_AWREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_AWADDR,
  input  logic                            s_axi_control_WVALID,
  output logic                            s_axi_control_WREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_control_WSTRB,
  output logic                            s_axi_control_BVALID,
  input  logic                            s_axi_control_BREADY,
  output logic [1:0]                      s_axi_control_BRESP,
  input  logic                            s_axi_control_ARVALID,
  output logic                            s_axi_control_ARREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_ARADDR,
  output logic                            s_axi_control_RVALID,
  input  logic                            s_axi_control_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_RDATA,
  output logic [1:0]                      s_axi_control_RRESP,
  output logic                            interrupt,
  output logic                            ap_start,
  input  logic                            ap_done,
  input  logic                            ap_ready,
  input  logic                            ap_idle,
  output logic [C_XFER_SIZE_WIDTH-1:0]    xfer_size,
  output logic [C_M_AXI_GMEM_ADDR_WIDTH-1:0] gmem_ptr
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned WW = C_S_AXI_ADDR_WIDTH - 2;

  localparam logic [WW-1:0] A_CTRL = WW'(0);
  localparam logic [WW-1:0] A_GIE  = WW'(1);
  localparam logic [WW-1:0] A_IER  = WW'(2);
  localparam logic [WW-1:0] A_ISR  = WW'(3);
  localparam logic [WW-1:0] A_XFER = WW'(4);
  localparam logic [WW-1:0] A_GLO  = WW'(6);
  localparam logic [WW-1:0] A_GHI  = WW'(7);

  typedef enum logic [1:0] {WRIDLE, WRDATA, WRRESP} wstate_e;
  typedef enum logic       {RDIDLE, RDDATA}         rstate_e;

  wstate_e         wstate_q, wstate_d;
  rstate_e         rstate_q, rstate_d;
  logic [WW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            ap_start_q, ap_start_d;
  logic            auto_restart_q, auto_restart_d;
  logic            done_st_q, done_st_d;
  logic            ready_st_q, ready_st_d;
  logic            gie_q, gie_d;
  logic [1:0]      ier_q, ier_d;
  logic [1:0]      isr_q, isr_d;
  logic            irq_q, irq_d;
  logic [DW-1:0]   xfer_q, xfer_d;
  logic [DW-1:0]   gmem_lo_q, gmem_lo_d;
  logic [DW-1:0]   gmem_hi_q, gmem_hi_d;

  logic            aw_hs_c, w_hs_c, ar_hs_c;
  logic [WW-1:0]   raddr_c;
  logic [DW-1:0]   wmask_c;
  logic [DW-1:0]   rdata_c;
  logic            unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi_control_AWADDR[1:0], s_axi_control_ARADDR[1:0]};

  assign s_axi_control_AWREADY = (wstate_q == WRIDLE);
  assign s_axi_control_WREADY  = (wstate_q == WRDATA);
  assign s_axi_control_BVALID  = (wstate_q == WRRESP);
  assign s_axi_control_BRESP   = 2'b00;
  assign s_axi_control_ARREADY = (rstate_q == RDIDLE);
  assign s_axi_control_RVALID  = (rstate_q == RDDATA);
  assign s_axi_control_RDATA   = rdata_q;
  assign s_axi_control_RRESP   = 2'b00;
  assign interrupt             = irq_q;
  assign ap_start              = ap_start_q;
  assign xfer_size             = C_XFER_SIZE_WIDTH'(xfer_q);
  assign gmem_ptr              = C_M_AXI_GMEM_ADDR_WIDTH'({gmem_hi_q, gmem_lo_q});

  assign aw_hs_c = s_axi_control_AWVALID & s_axi_control_AWREADY;
  assign w_hs_c  = s_axi_control_WVALID  & s_axi_control_WREADY;
  assign ar_hs_c = s_axi_control_ARVALID & s_axi_control_ARREADY;
  assign raddr_c = s_axi_control_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wmask_c = {{8{s_axi_control_WSTRB[3]}}, {8{s_axi_control_WSTRB[2]}},
                    {8{s_axi_control_WSTRB[1]}}, {8{s_axi_control_WSTRB[0]}}};

  // Write channel: AW, then W, then B; never AW and W together
  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      WRIDLE:  if (s_axi_control_AWVALID) wstate_d = WRDATA;
      WRDATA:  if (s_axi_control_WVALID)  wstate_d = WRRESP;
      WRRESP:  if (s_axi_control_BREADY)  wstate_d = WRIDLE;
      default: wstate_d = WRIDLE;
    endcase
  end

  // Read channel: data is registered at the AR handshake and held until RREADY
  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      RDIDLE:  if (s_axi_control_ARVALID) rstate_d = RDDATA;
      RDDATA:  if (s_axi_control_RREADY)  rstate_d = RDIDLE;
      default: rstate_d = RDIDLE;
    endcase
  end

  // Read data mux; CTRL reads return status before any clear-on-read
  always_comb begin
    rdata_c = '0;
    case (raddr_c)
      A_CTRL: begin
        rdata_c[0] = ap_start_q;
        rdata_c[1] = done_st_q;
        rdata_c[2] = ap_idle;
        rdata_c[3] = ready_st_q;
        rdata_c[7] = auto_restart_q;
      end
      A_GIE:   rdata_c[0]   = gie_q;
      A_IER:   rdata_c[1:0] = ier_q;
      A_ISR:   rdata_c[1:0] = isr_q;
      A_XFER:  rdata_c      = xfer_q;
      A_GLO:   rdata_c      = gmem_lo_q;
      A_GHI:   rdata_c      = gmem_hi_q;
      default: rdata_c      = '0;
    endcase
  end

  // Register next-state; kernel events take priority over software clears/toggles
  always_comb begin
    waddr_d        = waddr_q;
    rdata_d        = rdata_q;
    ap_start_d     = ap_start_q;
    auto_restart_d = auto_restart_q;
    done_st_d      = done_st_q;
    ready_st_d     = ready_st_q;
    gie_d          = gie_q;
    ier_d          = ier_q;
    isr_d          = isr_q;
    xfer_d         = xfer_q;
    gmem_lo_d      = gmem_lo_q;
    gmem_hi_d      = gmem_hi_q;
    irq_d          = gie_q & (|isr_q);

    if (aw_hs_c) waddr_d = s_axi_control_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    if (ar_hs_c) rdata_d = rdata_c;

    if (ap_ready && !auto_restart_q) ap_start_d = 1'b0;

    if (w_hs_c) begin
      case (waddr_q)
        A_CTRL: if (s_axi_control_WSTRB[0]) begin
          if (s_axi_control_WDATA[0]) ap_start_d = 1'b1;
          auto_restart_d = s_axi_control_WDATA[7];
        end
        A_GIE:  if (s_axi_control_WSTRB[0]) gie_d = s_axi_control_WDATA[0];
        A_IER:  if (s_axi_control_WSTRB[0]) ier_d = s_axi_control_WDATA[1:0];
        A_ISR:  if (s_axi_control_WSTRB[0]) isr_d = isr_q ^ s_axi_control_WDATA[1:0];
        A_XFER: xfer_d    = (xfer_q    & ~wmask_c) | (s_axi_control_WDATA & wmask_c);
        A_GLO:  gmem_lo_d = (gmem_lo_q & ~wmask_c) | (s_axi_control_WDATA & wmask_c);
        A_GHI:  gmem_hi_d = (gmem_hi_q & ~wmask_c) | (s_axi_control_WDATA & wmask_c);
        default: ;
      endcase
    end

    if (ar_hs_c && raddr_c == A_CTRL) begin
      done_st_d  = 1'b0;
      ready_st_d = 1'b0;
    end
    if (ap_done)  done_st_d  = 1'b1;
    if (ap_ready) ready_st_d = 1'b1;
    if (ap_done  && ier_q[0]) isr_d[0] = 1'b1;
    if (ap_ready && ier_q[1]) isr_d[1] = 1'b1;
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      wstate_q       <= WRIDLE;
      rstate_q       <= RDIDLE;
      waddr_q        <= '0;
      rdata_q        <= '0;
      ap_start_q     <= 1'b0;
      auto_restart_q <= 1'b0;
      done_st_q      <= 1'b0;
      ready_st_q     <= 1'b0;
      gie_q          <= 1'b0;
      ier_q          <= '0;
      isr_q          <= '0;
      irq_q          <= 1'b0;
      xfer_q         <= '0;
      gmem_lo_q      <= '0;
      gmem_hi_q      <= '0;
    end else begin
      wstate_q       <= wstate_d;
      rstate_q       <= rstate_d;
      waddr_q        <= waddr_d;
      rdata_q        <= rdata_d;
      ap_start_q     <= ap_start_d;
      auto_restart_q <= auto_restart_d;
      done_st_q      <= done_st_d;
      ready_st_q     <= ready_st_d;
      gie_q          <= gie_d;
      ier_q          <= ier_d;
      isr_q          <= isr_d;
      irq_q          <= irq_d;
      xfer_q         <= xfer_d;
      gmem_lo_q      <= gmem_lo_d;
      gmem_hi_q      <= gmem_hi_d;
    end
  end

endmodule

// File: tb/tb_byteswap_control_s_axi.sv
// Directed bench for byteswap_control_s_axi: vector table for register accesses,
// plus hand sequences for interrupt latency, auto-restart, same-cycle clear and reset mid-write.
module tb_byteswap_control_s_axi;

  localparam int OP_WR = 0;
  localparam int OP_RD = 1;
  localparam int OP_PR = 2;
  localparam int OP_PD = 3;
  localparam int NVEC  = 20;

  logic        clk = 1'b0;
  logic        areset;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [5:0]  awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        irq, ap_start, ap_done, ap_ready, ap_idle;
  logic [31:0] xfer_size;
  logic [63:0] gmem_ptr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          op;
    logic        idle;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_start;
    logic [31:0] exp_xfer;
    logic [63:0] exp_gmem;
  } vec_t;

  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  byteswap_control_s_axi dut (
    .ap_clk(clk), .areset(areset),
    .s_axi_control_AWVALID(awvalid), .s_axi_control_AWREADY(awready),
    .s_axi_control_AWADDR(awaddr),
    .s_axi_control_WVALID(wvalid), .s_axi_control_WREADY(wready),
    .s_axi_control_WDATA(wdata), .s_axi_control_WSTRB(wstrb),
    .s_axi_control_BVALID(bvalid), .s_axi_control_BREADY(bready),
    .s_axi_control_BRESP(bresp),
    .s_axi_control_ARVALID(arvalid), .s_axi_control_ARREADY(arready),
    .s_axi_control_ARADDR(araddr),
    .s_axi_control_RVALID(rvalid), .s_axi_control_RREADY(rready),
    .s_axi_control_RDATA(rdata), .s_axi_control_RRESP(rresp),
    .interrupt(irq), .ap_start(ap_start), .ap_done(ap_done),
    .ap_ready(ap_ready), .ap_idle(ap_idle),
    .xfer_size(xfer_size), .gmem_ptr(gmem_ptr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b0;
    while (awready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("wr_awready_wait", 64'(awready), 64'd1);
    @(posedge clk); #1 awvalid = 1'b0;
    chk("wr_w_phase", 64'({awready, wready, bvalid}), 64'b010);
    @(posedge clk); #1 wvalid = 1'b0;
    chk("wr_bvalid", 64'({bvalid, bresp}), 64'b100);
    bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
    chk("wr_done", 64'({bvalid, awready}), 64'b01);
  endtask

  task automatic axi_read(input logic [5:0] a, input logic with_done, output logic [31:0] d);
    int n = 0;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b0; ap_done = with_done;
    while (arready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("rd_arready_wait", 64'(arready), 64'd1);
    @(posedge clk); #1 arvalid = 1'b0; ap_done = 1'b0;
    chk("rd_rvalid_next", 64'({rvalid, arready, rresp}), 64'b1000);
    d = rdata;
    @(posedge clk); #1;
    chk("rd_hold", 64'({rvalid, rdata}), 64'({1'b1, d}));
    rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
    chk("rd_done", 64'({rvalid, arready}), 64'b01);
  endtask

  task automatic pulse(input logic is_ready);
    @(negedge clk);
    if (is_ready) ap_ready = 1'b1; else ap_done = 1'b1;
    @(posedge clk); #1 ap_ready = 1'b0; ap_done = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    vecs[0]  = '{OP_RD, 1'b1, 6'h00, 32'h0,        4'h0, 32'h00000004, 1'b0, 32'h0,        64'h0};
    vecs[1]  = '{OP_WR, 1'b1, 6'h10, 32'h00001000, 4'hF, 32'h0,        1'b0, 32'h00001000, 64'h0};
    vecs[2]  = '{OP_WR, 1'b1, 6'h18, 32'h80000000, 4'hF, 32'h0,        1'b0, 32'h00001000, 64'h0000000080000000};
    vecs[3]  = '{OP_WR, 1'b1, 6'h1C, 32'h00000001, 4'hF, 32'h0,        1'b0, 32'h00001000, 64'h0000000180000000};
    vecs[4]  = '{OP_RD, 1'b1, 6'h10, 32'h0,        4'h0, 32'h00001000, 1'b0, 32'h00001000, 64'h0000000180000000};
    vecs[5]  = '{OP_RD, 1'b1, 6'h1C, 32'h0,        4'h0, 32'h00000001, 1'b0, 32'h00001000, 64'h0000000180000000};
    vecs[6]  = '{OP_RD, 1'b1, 6'h1B, 32'h0,        4'h0, 32'h80000000, 1'b0, 32'h00001000, 64'h0000000180000000};
    vecs[7]  = '{OP_WR, 1'b1, 6'h10, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 32'h00BB10DD, 64'h0000000180000000};
    vecs[8]  = '{OP_WR, 1'b1, 6'h14, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b0, 32'h00BB10DD, 64'h0000000180000000};
    vecs[9]  = '{OP_RD, 1'b1, 6'h14, 32'h0,        4'h0, 32'h00000000, 1'b0, 32'h00BB10DD, 64'h0000000180000000};
    vecs[10] = '{OP_WR, 1'b1, 6'h1C, 32'h12345678, 4'h0, 32'h0,        1'b0, 32'h00BB10DD, 64'h0000000180000000};
    vecs[11] = '{OP_WR, 1'b0, 6'h00, 32'h00000001, 4'hF, 32'h0,        1'b1, 32'h00BB10DD, 64'h0000000180000000};
    vecs[12] = '{OP_RD, 1'b0, 6'h00, 32'h0,        4'h0, 32'h00000001, 1'b1, 32'h00BB10DD, 64'h0000000180000000};
    vecs[13] = '{OP_PR, 1'b0, 6'h00, 32'h0,        4'h0, 32'h0,        1'b0, 32'h00BB10DD, 64'h0000000180000000};
    vecs[14] = '{OP_PD, 1'b0, 6'h00, 32'h0,        4'h0, 32'h0,        1'b0, 32'h00BB10DD, 64'h0000000180000000};
    vecs[15] = '{OP_RD, 1'b0, 6'h00, 32'h0,        4'h0, 32'h0000000A, 1'b0, 32'h00BB10DD, 64'h0000000180000000};
    vecs[16] = '{OP_RD, 1'b0, 6'h00, 32'h0,        4'h0, 32'h00000000, 1'b0, 32'h00BB10DD, 64'h0000000180000000};
    vecs[17] = '{OP_WR, 1'b1, 6'h00, 32'h00000001, 4'h0, 32'h0,        1'b0, 32'h00BB10DD, 64'h0000000180000000};
    vecs[18] = '{OP_RD, 1'b1, 6'h0C, 32'h0,        4'h0, 32'h00000000, 1'b0, 32'h00BB10DD, 64'h0000000180000000};
    vecs[19] = '{OP_RD, 1'b1, 6'h00, 32'h0,        4'h0, 32'h00000004, 1'b0, 32'h00BB10DD, 64'h0000000180000000};

    areset = 1'b1;
    awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b0;
    arvalid = 1'b0; araddr = '0; rready = 1'b0;
    ap_done = 1'b0; ap_ready = 1'b0; ap_idle = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({awready, wready, bvalid, arready, rvalid, ap_start, irq}), 64'b1001000);
    chk("reset_regs", 64'({rdata, xfer_size}), 64'h0);
    chk("reset_gmem", gmem_ptr, 64'h0);
    areset = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_ready", 64'({awready, arready}), 64'b11);

    for (int i = 0; i < NVEC; i++) begin
      ap_idle = vecs[i].idle;
      case (vecs[i].op)
        OP_WR: axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
        OP_RD: begin
          axi_read(vecs[i].addr, 1'b0, rd);
          chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
        end
        OP_PR: pulse(1'b1);
        default: pulse(1'b0);
      endcase
      chk($sformatf("vec%0d_ap_start", i), 64'(ap_start), 64'(vecs[i].exp_start));
      chk($sformatf("vec%0d_xfer", i), 64'(xfer_size), 64'(vecs[i].exp_xfer));
      chk($sformatf("vec%0d_gmem", i), gmem_ptr, vecs[i].exp_gmem);
      chk($sformatf("vec%0d_irq", i), 64'(irq), 64'd0);
    end

    // Interrupt path: ISR set, one-cycle output latency, toggle semantics
    ap_idle = 1'b1;
    axi_write(6'h04, 32'h1, 4'hF);
    axi_write(6'h08, 32'h1, 4'hF);
    pulse(1'b0);
    chk("irq_lat0", 64'(irq), 64'd0);
    @(posedge clk); #1;
    chk("irq_lat1", 64'(irq), 64'd1);
    axi_write(6'h0C, 32'h1, 4'h0);
    chk("isr_strb0_irq", 64'(irq), 64'd1);
    axi_read(6'h0C, 1'b0, rd);
    chk("isr_after_done", 64'(rd), 64'h1);
    axi_write(6'h0C, 32'h1, 4'hF);
    chk("isr_clear_irq", 64'(irq), 64'd0);
    axi_write(6'h0C, 32'h2, 4'hF);
    axi_read(6'h0C, 1'b0, rd);
    chk("isr_toggle_set", 64'({irq, rd}), 64'({1'b1, 32'h2}));
    axi_write(6'h0C, 32'h2, 4'hF);
    pulse(1'b1);
    axi_read(6'h0C, 1'b0, rd);
    chk("isr_ready_masked", 64'({irq, rd}), 64'({1'b0, 32'h0}));
    axi_read(6'h00, 1'b0, rd);
    chk("ctrl_status_set", 64'(rd), 64'h0E);
    axi_read(6'h00, 1'b0, rd);
    chk("ctrl_status_cleared", 64'(rd), 64'h04);

    // auto_restart keeps ap_start high across ap_ready
    axi_write(6'h00, 32'h81, 4'hF);
    axi_read(6'h00, 1'b0, rd);
    chk("auto_ctrl", 64'({ap_start, rd}), 64'({1'b1, 32'h85}));
    pulse(1'b1);
    chk("auto_ready1", 64'(ap_start), 64'd1);
    pulse(1'b1);
    chk("auto_ready2", 64'(ap_start), 64'd1);
    axi_read(6'h00, 1'b0, rd);
    chk("auto_ready_status", 64'(rd), 64'h8D);
    axi_read(6'h00, 1'b1, rd);
    chk("same_cycle_read", 64'(rd), 64'h85);
    axi_read(6'h00, 1'b0, rd);
    chk("same_cycle_kept", 64'(rd), 64'h87);

    // Asynchronous reset while a write response is pending
    @(negedge clk);
    awaddr = 6'h10; awvalid = 1'b1; wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1 awvalid = 1'b0;
    @(posedge clk); #1 wvalid = 1'b0;
    chk("mid_bvalid", 64'({bvalid, xfer_size}), 64'({1'b1, 32'h5}));
    #2 areset = 1'b1;
    #1;
    chk("async_rst_ctl", 64'({bvalid, ap_start, irq, awready, wready, rvalid}), 64'b000100);
    chk("async_rst_xfer", 64'(xfer_size), 64'h0);
    chk("async_rst_gmem", gmem_ptr, 64'h0);
    @(negedge clk) areset = 1'b0;
    @(posedge clk); #1;
    chk("rst_release", 64'({awready, arready, bvalid}), 64'b110);
    axi_read(6'h00, 1'b0, rd);
    chk("rst_ctrl_read", 64'(rd), 64'h04);
    axi_read(6'h10, 1'b0, rd);
    chk("rst_xfer_read", 64'(rd), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
